// File: rtl/riscv_enc_pkg.sv
// rtl/riscv_enc_pkg.sv - opcode, command and state encodings for the instruction injector
package riscv_enc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CMD_LUI    = 4'd0;
  localparam logic [3:0] CMD_AUIPC  = 4'd1;
  localparam logic [3:0] CMD_JAL    = 4'd2;
  localparam logic [3:0] CMD_JALR   = 4'd3;
  localparam logic [3:0] CMD_BRANCH = 4'd4;
  localparam logic [3:0] CMD_LOAD   = 4'd5;
  localparam logic [3:0] CMD_STORE  = 4'd6;
  localparam logic [3:0] CMD_OPIMM  = 4'd7;
  localparam logic [3:0] CMD_OP     = 4'd8;
  localparam logic [3:0] CMD_MULDIV = 4'd9;
  localparam logic [3:0] CMD_CSR    = 4'd10;
  localparam logic [3:0] CMD_ECALL  = 4'd11;
  localparam logic [3:0] CMD_EBREAK = 4'd12;
  localparam logic [3:0] CMD_MRET   = 4'd13;
  localparam logic [3:0] CMD_LI     = 4'd14;
  localparam logic [3:0] CMD_RSVD   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERR   = 2'd1,
    ST_EMIT0 = 2'd2,
    ST_EMIT1 = 2'd3
  } inj_state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // An immediate fits a single ADDI when bits 31..11 are a pure sign extension.
  function automatic logic li_is_small(input logic [31:0] imm);
    return (&imm[31:11]) | ~(|imm[31:11]);
  endfunction

  // Rounding by 0x800 compensates for the sign-extended low ADDI part.
  function automatic logic [19:0] li_hi(input logic [31:0] imm);
    logic [31:0] w_sum;
    w_sum = imm + 32'h0000_0800;
    return w_sum[31:12];
  endfunction

endpackage

// File: rtl/rv_fmt_encode.sv
// rtl/rv_fmt_encode.sv - packs RV32 R/I/S/B/U/J instruction formats from discrete fields
module rv_fmt_encode
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/instr_injector.sv
// rtl/instr_injector.sv - turns abstract commands into RV32IM/Zicsr words for fetch injection
module instr_injector
  import riscv_enc_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [2:0]  cmd_funct3_i,
  input  logic        cmd_alt_i,
  input  logic [31:0] cmd_imm_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  input  logic        instr_ready_i,
  output logic        last_o,
  output logic        err_o,
  output logic        busy_o
);

  // A nonzero parameter value keeps the block from ever accepting a command.
  localparam logic P_PARAM_OK = (RESET_PC_UNUSED == 0);

  inj_state_t  r_state;
  inj_state_t  w_next;
  logic [3:0]  r_op;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_f3;
  logic        r_alt;
  logic [31:0] r_imm;

  logic        w_accept;
  logic        w_illegal;
  logic        w_li_two;
  logic        w_valid;
  logic [31:0] w_word;

  logic [2:0]  w_fmt;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;

  assign w_accept = cmd_valid_i & (r_state == ST_IDLE) & P_PARAM_OK;
  assign w_li_two = (r_op == CMD_LI) & ~li_is_small(r_imm) & (r_imm[11:0] != 12'd0);

  always_comb begin
    w_illegal = 1'b0;
    case (cmd_op_i)
      CMD_BRANCH: w_illegal = (cmd_funct3_i == 3'd2) | (cmd_funct3_i == 3'd3);
      CMD_LOAD:   w_illegal = (cmd_funct3_i == 3'd3) | (cmd_funct3_i == 3'd6) |
                              (cmd_funct3_i == 3'd7);
      CMD_STORE:  w_illegal = (cmd_funct3_i > 3'd2);
      CMD_CSR:    w_illegal = (cmd_funct3_i == 3'd0) | (cmd_funct3_i == 3'd4);
      CMD_OP:     w_illegal = cmd_alt_i & (cmd_funct3_i != 3'd0) & (cmd_funct3_i != 3'd5);
      CMD_OPIMM:  w_illegal = cmd_alt_i & (cmd_funct3_i != 3'd5);
      CMD_RSVD:   w_illegal = 1'b1;
      default:    w_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_f3  <= '0;
      r_alt <= 1'b0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= cmd_op_i;
      r_rd  <= cmd_rd_i;
      r_rs1 <= cmd_rs1_i;
      r_rs2 <= cmd_rs2_i;
      r_f3  <= cmd_funct3_i;
      r_alt <= cmd_alt_i;
      r_imm <= cmd_imm_i;
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready_o = 1'b0;
    w_valid     = 1'b0;
    last_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = P_PARAM_OK;
        busy_o      = 1'b0;
        if (w_accept) begin
          w_next = w_illegal ? ST_ERR : ST_EMIT0;
        end
      end
      ST_ERR: begin
        err_o  = 1'b1;
        w_next = ST_IDLE;
      end
      ST_EMIT0: begin
        w_valid = 1'b1;
        last_o  = ~w_li_two;
        if (instr_ready_i) begin
          w_next = w_li_two ? ST_EMIT1 : ST_IDLE;
        end
      end
      ST_EMIT1: begin
        w_valid = 1'b1;
        last_o  = 1'b1;
        if (instr_ready_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Field selection for the format packer; the second LI word is ADDI rd,rd,lo.
  always_comb begin
    w_fmt = FMT_I;
    w_opc = OPC_OPIMM;
    w_f3  = r_f3;
    w_f7  = 7'd0;
    w_rd  = r_rd;
    w_rs1 = r_rs1;
    w_rs2 = r_rs2;
    w_imm = r_imm;
    case (r_op)
      CMD_LUI:    begin w_fmt = FMT_U; w_opc = OPC_LUI;    end
      CMD_AUIPC:  begin w_fmt = FMT_U; w_opc = OPC_AUIPC;  end
      CMD_JAL:    begin w_fmt = FMT_J; w_opc = OPC_JAL;    end
      CMD_JALR:   begin w_fmt = FMT_I; w_opc = OPC_JALR; w_f3 = 3'd0; end
      CMD_BRANCH: begin w_fmt = FMT_B; w_opc = OPC_BRANCH; end
      CMD_LOAD:   begin w_fmt = FMT_I; w_opc = OPC_LOAD;   end
      CMD_STORE:  begin w_fmt = FMT_S; w_opc = OPC_STORE;  end
      CMD_OPIMM: begin
        if ((r_f3 == 3'd1) || (r_f3 == 3'd5)) begin
          w_imm = {20'd0, 1'b0, r_alt, 5'd0, r_imm[4:0]};
        end
      end
      CMD_OP: begin
        w_fmt = FMT_R;
        w_opc = OPC_OP;
        w_f7  = {1'b0, r_alt, 5'd0};
      end
      CMD_MULDIV: begin
        w_fmt = FMT_R;
        w_opc = OPC_OP;
        w_f7  = 7'b0000001;
      end
      CMD_CSR: w_opc = OPC_SYSTEM;
      CMD_ECALL, CMD_EBREAK, CMD_MRET: begin
        w_opc = OPC_SYSTEM;
        w_f3  = 3'd0;
        w_rd  = 5'd0;
        w_rs1 = 5'd0;
        w_imm = (r_op == CMD_ECALL)  ? 32'h0000_0000 :
                (r_op == CMD_EBREAK) ? 32'h0000_0001 : 32'h0000_0302;
      end
      CMD_LI: begin
        w_f3 = 3'd0;
        if (r_state == ST_EMIT1) begin
          w_rs1 = r_rd;
        end else if (li_is_small(r_imm)) begin
          w_rs1 = 5'd0;
        end else begin
          w_fmt = FMT_U;
          w_opc = OPC_LUI;
          w_imm = {li_hi(r_imm), 12'd0};
        end
      end
      default: w_fmt = FMT_I;
    endcase
  end

  rv_fmt_encode u_fmt (
    .i_fmt    (w_fmt),
    .i_opcode (w_opc),
    .i_funct3 (w_f3),
    .i_funct7 (w_f7),
    .i_rd     (w_rd),
    .i_rs1    (w_rs1),
    .i_rs2    (w_rs2),
    .i_imm    (w_imm),
    .o_word   (w_word)
  );

  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? w_word : 32'd0;

endmodule

// File: tb/tb_instr_injector.sv
// tb/tb_instr_injector.sv - directed self-checking bench with a reference encoding model
module tb_instr_injector;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_op_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [4:0]  cmd_rs2_i;
  logic [2:0]  cmd_funct3_i;
  logic        cmd_alt_i;
  logic [31:0] cmd_imm_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        instr_ready_i;
  logic        last_o;
  logic        err_o;
  logic        busy_o;

  instr_injector #(.RESET_PC_UNUSED(0)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i),
    .cmd_rs2_i(cmd_rs2_i), .cmd_funct3_i(cmd_funct3_i), .cmd_alt_i(cmd_alt_i),
    .cmd_imm_i(cmd_imm_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_ready_i(instr_ready_i), .last_o(last_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] w; logic last; } exp_t;
  typedef struct {
    logic [3:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic alt; logic [31:0] imm;
  } cmd_t;

  exp_t        exp_q[$];
  logic [31:0] seen_q[$];
  cmd_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          err_pend = 0;
  int          err_seen = 0;
  int          valid_cycles = 0;
  logic        seen_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
           (32'(rd) << 7) | 32'(opc);
  endfunction

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
           (32'(rd) << 7) | 32'h33;
  endfunction

  // Reference: what an assembler would produce for each abstract command.
  function automatic void model(input cmd_t c, output logic err, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] imm, lo, lo_s, sh;
    imm = c.imm; err = 1'b0; n = 1; w0 = '0; w1 = '0;
    case (c.op)
      4'd0:  w0 = (imm & 32'hFFFFF000) | (32'(c.rd) << 7) | 32'h37;
      4'd1:  w0 = (imm & 32'hFFFFF000) | (32'(c.rd) << 7) | 32'h17;
      4'd2:  w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                  (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                  (32'(c.rd) << 7) | 32'h6F;
      4'd3:  w0 = enc_i(imm, c.rs1, 3'd0, c.rd, 7'h67);
      4'd4: begin
        err = (c.f3 == 3'd2) || (c.f3 == 3'd3);
        w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
             (32'(c.rs2) << 20) | (32'(c.rs1) << 15) | (32'(c.f3) << 12) |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      4'd5: begin
        err = (c.f3 == 3'd3) || (c.f3 >= 3'd6);
        w0 = enc_i(imm, c.rs1, c.f3, c.rd, 7'h03);
      end
      4'd6: begin
        err = c.f3 > 3'd2;
        w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(c.rs2) << 20) | (32'(c.rs1) << 15) |
             (32'(c.f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
      end
      4'd7: begin
        err = c.alt && (c.f3 != 3'd5);
        sh = (imm & 32'h1F) + (c.alt ? 32'h400 : 32'h0);
        w0 = enc_i(((c.f3 == 3'd1) || (c.f3 == 3'd5)) ? sh : imm, c.rs1, c.f3, c.rd, 7'h13);
      end
      4'd8: begin
        err = c.alt && (c.f3 != 3'd0) && (c.f3 != 3'd5);
        w0 = enc_r(c.alt ? 32'h20 : 32'h0, c.rs2, c.rs1, c.f3, c.rd);
      end
      4'd9:  w0 = enc_r(32'h1, c.rs2, c.rs1, c.f3, c.rd);
      4'd10: begin
        err = (c.f3 == 3'd0) || (c.f3 == 3'd4);
        w0 = enc_i(imm, c.rs1, c.f3, c.rd, 7'h73);
      end
      4'd11: w0 = 32'h00000073;
      4'd12: w0 = 32'h00100073;
      4'd13: w0 = 32'h30200073;
      4'd14: begin
        lo   = imm & 32'hFFF;
        lo_s = (lo ^ 32'h800) - 32'h800;
        if (lo_s == imm) begin
          w0 = enc_i(lo, 5'd0, 3'd0, c.rd, 7'h13);
        end else begin
          w0 = (imm - lo_s) | (32'(c.rd) << 7) | 32'h37;
          if (lo != 0) begin
            n = 2;
            w1 = enc_i(lo, c.rd, 3'd0, c.rd, 7'h13);
          end
        end
      end
      default: err = 1'b1;
    endcase
  endfunction

  // Compare process: every valid word against the model, every err pulse against expectations.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (instr_valid_o) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(instr_valid_o), 32'd0);
        end else begin
          chk("word", instr_o, exp_q[0].w);
          chk("last", 32'(last_o), 32'(exp_q[0].last));
          if (instr_ready_i) begin
            seen_q.push_back(instr_o);
            seen_last = last_o;
            void'(exp_q.pop_front());
          end
        end
      end
      if (err_o) begin
        err_seen++;
        if (err_pend == 0) chk("unexpected_err", 32'(err_o), 32'd0);
        else err_pend--;
        chk("err_without_valid", 32'(instr_valid_o), 32'd0);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                      input logic [31:0] imm);
    cmd_t c; logic e; int n; logic [31:0] w0, w1; int guard;
    c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2; c.f3 = f3; c.alt = alt; c.imm = imm;
    @(negedge clk_i);
    cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2;
    cmd_funct3_i = f3; cmd_alt_i = alt; cmd_imm_i = imm; cmd_valid_i = 1'b1;
    guard = 0;
    while (!cmd_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!cmd_ready_o) begin
      cmd_valid_i = 1'b0;
      chk("accept_timeout", 32'(cmd_ready_o), 32'd1);
    end else begin
      model(c, e, n, w0, w1);
      if (e) err_pend++;
      else begin
        exp_q.push_back('{w: w0, last: (n == 1)});
        if (n == 2) exp_q.push_back('{w: w1, last: 1'b1});
      end
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!(exp_q.size() == 0 && err_pend == 0 && cmd_ready_o) && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    chk("drain_timeout", 32'(exp_q.size() + err_pend), 32'd0);
  endtask

  task automatic add(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                     input logic [31:0] imm);
    tbl.push_back('{op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, alt: alt, imm: imm});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t pc; logic pe; int pn; logic [31:0] p0, p1; int vc, n0, e0;
    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_rd_i = '0; cmd_rs1_i = '0;
    cmd_rs2_i = '0; cmd_funct3_i = '0; cmd_alt_i = 1'b0; cmd_imm_i = '0; instr_ready_i = 1'b1;
    seen_last = 1'b0;

    pc = '{op: 4'd14, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: 32'h12345FFF};
    model(pc, pe, pn, p0, p1);
    chk("model_li_w0", p0, 32'h123462B7);
    chk("model_li_w1", p1, 32'hFFF28293);
    chk("model_li_n", 32'(pn), 32'd2);
    pc = '{op: 4'd8, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, alt: 1'b0, imm: 32'h0};
    model(pc, pe, pn, p0, p1);
    chk("model_add", p0, 32'h002081B3);

    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // ADD with ready high: one valid cycle, ready for a new command right after.
    vc = valid_cycles;
    send(4'd8, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("add_valid", 32'(instr_valid_o), 32'd1);
    chk("add_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
    chk("add_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    #1;
    chk("add_cmd_ready_back", 32'(cmd_ready_o), 32'd1);
    chk("add_valid_gone", 32'(instr_valid_o), 32'd0);
    chk("add_word", seen_q[seen_q.size()-1], 32'h002081B3);
    chk("add_valid_cycles", 32'(valid_cycles - vc), 32'd1);

    // LI needing two words, core stalls the first word for three cycles.
    instr_ready_i = 1'b0;
    send(4'd14, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    repeat (3) begin
      @(negedge clk_i);
      chk("li_stall_word", instr_o, 32'h123462B7);
      chk("li_stall_last", 32'(last_o), 32'd0);
    end
    @(posedge clk_i);
    #1 instr_ready_i = 1'b1;
    @(negedge clk_i);
    chk("li_hs_word0", instr_o, 32'h123462B7);
    @(negedge clk_i);
    chk("li_word1", instr_o, 32'hFFF28293);
    chk("li_word1_last", 32'(last_o), 32'd1);
    wait_idle();

    send(4'd14, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFB);
    wait_idle();
    chk("li_small_word", seen_q[seen_q.size()-1], 32'hFFB00093);
    chk("li_small_last", 32'(seen_last), 32'd1);
    send(4'd14, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00010000);
    wait_idle();
    chk("li_lui_only_word", seen_q[seen_q.size()-1], 32'h000100B7);
    chk("li_lui_only_last", 32'(seen_last), 32'd1);

    // Illegal LOAD funct3: one err pulse, no word.
    send(4'd5, 5'd2, 5'd3, 5'd0, 3'd3, 1'b0, 32'h10);
    @(negedge clk_i);
    chk("ld_err_pulse", 32'(err_o), 32'd1);
    chk("ld_err_no_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("ld_err_done", 32'(err_o), 32'd0);
    chk("ld_err_ready", 32'(cmd_ready_o), 32'd1);

    n0 = seen_q.size();
    send(4'd13, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0);
    send(4'd11, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0);
    wait_idle();
    chk("mret_word", seen_q[n0], 32'h30200073);
    chk("ecall_word", seen_q[n0+1], 32'h00000073);

    e0 = err_seen;
    send(4'd10, 5'd1, 5'd2, 5'd0, 3'd4, 1'b0, 32'h300);
    wait_idle();
    chk("csr_f3_4_err", 32'(err_seen - e0), 32'd1);

    add(4'd0, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE123);
    add(4'd1, 5'd8, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001FFF);
    add(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h000FF7FF);
    add(4'd3, 5'd1, 5'd5, 5'd0, 3'd3, 1'b0, 32'h000007FF);
    add(4'd4, 5'd0, 5'd3, 5'd4, 3'd1, 1'b0, 32'hFFFFF800);
    add(4'd4, 5'd0, 5'd3, 5'd4, 3'd2, 1'b0, 32'h00000010);
    add(4'd5, 5'd9, 5'd2, 5'd0, 3'd4, 1'b0, 32'h00000FFF);
    add(4'd5, 5'd9, 5'd2, 5'd0, 3'd6, 1'b0, 32'h00000004);
    add(4'd6, 5'd0, 5'd2, 5'd9, 3'd2, 1'b0, 32'h000007E5);
    add(4'd6, 5'd0, 5'd2, 5'd9, 3'd3, 1'b0, 32'h00000008);
    add(4'd7, 5'd4, 5'd6, 5'd0, 3'd5, 1'b1, 32'h0000003F);
    add(4'd7, 5'd4, 5'd6, 5'd0, 3'd1, 1'b0, 32'h00000007);
    add(4'd7, 5'd4, 5'd6, 5'd0, 3'd0, 1'b1, 32'h00000001);
    add(4'd7, 5'd4, 5'd6, 5'd0, 3'd4, 1'b0, 32'h80000ABC);
    add(4'd8, 5'd10, 5'd11, 5'd12, 3'd0, 1'b1, 32'h0);
    add(4'd8, 5'd10, 5'd11, 5'd12, 3'd1, 1'b1, 32'h0);
    add(4'd9, 5'd13, 5'd14, 5'd15, 3'd4, 1'b0, 32'h0);
    add(4'd10, 5'd5, 5'd6, 5'd0, 3'd2, 1'b0, 32'h00000342);
    add(4'd10, 5'd5, 5'd31, 5'd0, 3'd5, 1'b0, 32'h00000F14);
    add(4'd10, 5'd5, 5'd6, 5'd0, 3'd0, 1'b0, 32'h00000342);
    add(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0);
    add(4'd14, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800);
    add(4'd14, 5'd11, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF800);
    add(4'd14, 5'd12, 5'd0, 5'd0, 3'd0, 1'b0, 32'h7FFFFFFF);
    add(4'd14, 5'd13, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000000);
    add(4'd15, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h0);
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].alt, tbl[i].imm);
    end
    wait_idle();

    // Reset while the first LI word is stalled drops the whole command.
    instr_ready_i = 1'b0;
    send(4'd14, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    @(negedge clk_i);
    chk("rst_mid_valid_before", 32'(instr_valid_o), 32'd1);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    exp_q.delete();
    err_pend = 0;
    @(negedge clk_i);
    chk("rst_mid_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    instr_ready_i = 1'b1;
    vc = valid_cycles;
    repeat (10) @(negedge clk_i);
    #1;
    chk("rst_mid_no_second", 32'(valid_cycles - vc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
